// File: rtl/apb_initiator_if.sv
// Request/response handshake and APB bus signals of the APB initiator.
// The master modport is the initiator's view; slave is the requester/peripheral side.
interface apb_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [17:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic [17:0] PADDR;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PADDR, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PADDR, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_initiator.sv
// APB initiator: single-outstanding valid/ready requests become SETUP/ACCESS
// transfers, with PREADY wait states and an optional stall timeout.
module apb_initiator #(
  parameter logic [15:0] TIMEOUT = 16'd255
) (
  input  logic             PCLK,
  input  logic             PRESET,
  apb_initiator_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT - 16'd1;

  state_t      state;
  logic [15:0] wait_cnt;
  logic        accept;

  // Ready depends only on state and reset, so the requester never sees a
  // combinational loop through req_valid.
  assign bus.req_ready = (state == IDLE) && !PRESET;
  assign accept        = bus.req_valid && bus.req_ready;

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch reads the pre-edge values, regardless of statement order.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state         <= IDLE;
      wait_cnt      <= 16'd0;
      bus.PSEL      <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= 18'd0;
      bus.PWDATA    <= 32'd0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= 32'd0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= SETUP;
            bus.PSEL   <= 1'b1;
            bus.PADDR  <= bus.req_addr;
            bus.PWRITE <= bus.req_write;
            bus.PWDATA <= bus.req_wdata;
          end
        end

        SETUP: begin
          state       <= ACCESS;
          bus.PENABLE <= 1'b1;
          wait_cnt    <= 16'd0;
        end

        ACCESS: begin
          if (bus.PREADY) begin
            state         <= IDLE;
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= bus.PWRITE ? 32'd0 : bus.PRDATA;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
            // Abort only when the last allowed ACCESS cycle also stalls.
            if ((TIMEOUT != 16'd0) && (wait_cnt == TIMEOUT_LAST)) begin
              state         <= IDLE;
              bus.PSEL      <= 1'b0;
              bus.PENABLE   <= 1'b0;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= 32'hDEADBEEF;
            end
          end
        end

        default: begin
          state       <= IDLE;
          bus.PSEL    <= 1'b0;
          bus.PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_initiator.sv
// Scoreboard bench for apb_initiator: the driver queues expected responses,
// a monitor pops and compares them on every rsp_valid strobe.
module tb_apb_initiator;

  localparam int TB_TIMEOUT = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic PCLK;
  logic PRESET;
  apb_initiator_if bus();

  apb_initiator #(.TIMEOUT(16'(TB_TIMEOUT))) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  exp_t        exp_q[$];
  logic [2:0]  phase_log [4096];

  // Responder configuration (set by driver) and per-transfer copies taken at accept.
  int          cfg_wait   = 0;
  logic [31:0] cfg_prdata = '0;
  int          m_wait     = 0;
  logic [31:0] m_prdata   = '0;
  logic [17:0] m_addr     = '0;
  logic        m_write    = 1'b0;
  logic [31:0] m_wdata    = '0;
  int          acc_n      = 0;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  always @(posedge PCLK) begin
    if (bus.req_valid && bus.req_ready) begin
      m_addr   <= bus.req_addr;
      m_write  <= bus.req_write;
      m_wdata  <= bus.req_wdata;
      m_wait   <= cfg_wait;
      m_prdata <= cfg_prdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // APB peripheral model: inserts m_wait wait states, checks address phase stability.
  initial begin
    forever begin
      @(negedge PCLK);
      if (bus.PSEL) begin
        check("paddr_stable",  32'(bus.PADDR),  32'(m_addr));
        check("pwrite_stable", 32'(bus.PWRITE), 32'(m_write));
        check("pwdata_stable", bus.PWDATA,      m_wdata);
      end
      if (bus.PSEL && bus.PENABLE) begin
        bus.PREADY = (acc_n == m_wait);
        bus.PRDATA = (acc_n == m_wait) ? m_prdata : 32'h0BAD0BAD;
        acc_n++;
      end else begin
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'h0BAD0BAD;
        acc_n = 0;
      end
    end
  end

  // Response monitor and phase logger.
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      phase_log[cyc % 4096] = {bus.PSEL, bus.PENABLE, bus.req_ready};
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got rsp_valid with rdata %h err %b, required no response (cycle %0d)",
                   bus.rsp_rdata, bus.rsp_err, cyc);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", bus.rsp_rdata, e.rdata);
          check("rsp_err",   32'(bus.rsp_err), 32'(e.err));
          check("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic phase(input string name, input int k, input logic [2:0] exp);
    check(name, 32'(phase_log[k % 4096]), 32'(exp));
  endtask

  // Called at a negedge; returns at the negedge after the accept edge with req_valid still high.
  task automatic issue(input logic wr, input logic [17:0] addr, input logic [31:0] wd,
                       input int nwait, input logic [31:0] rd, input bit want_rsp,
                       output int acc);
    exp_t e;
    int   budget;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    cfg_wait      = nwait;
    cfg_prdata    = rd;
    budget        = 0;
    while (!bus.req_ready && budget < 100) begin
      @(negedge PCLK);
      budget++;
    end
    if (!bus.req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_ready_wait: req_ready stayed 0 for %0d cycles, required 1", budget);
      bus.req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (want_rsp) begin
      if (nwait >= TB_TIMEOUT) e = '{32'hDEADBEEF, 1'b1, acc + 2 + TB_TIMEOUT};
      else                     e = '{(wr ? 32'h0 : rd), 1'b0, acc + 3 + nwait};
      exp_q.push_back(e);
    end
    @(negedge PCLK);
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      @(negedge PCLK);
      budget++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge PCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int a, a2;
    PRESET        = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 18'h3;
    bus.req_wdata = 32'hFFFFFFFF;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = '0;

    // Reset held 2 cycles with a request pending.
    repeat (2) begin
      @(negedge PCLK);
      check("rst_psel",      32'(bus.PSEL),      32'd0);
      check("rst_penable",   32'(bus.PENABLE),   32'd0);
      check("rst_pwrite",    32'(bus.PWRITE),    32'd0);
      check("rst_paddr",     32'(bus.PADDR),     32'd0);
      check("rst_pwdata",    bus.PWDATA,         32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    end
    PRESET        = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge PCLK);
    check("post_rst_psel",  32'(bus.PSEL),      32'd0);
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);

    // Zero-wait write.
    issue(1'b1, 18'h1, 32'h12345678, 0, 32'h0, 1'b1, a);
    bus.req_valid = 1'b0;
    drain();
    phase("wr0_setup",  a + 1, 3'b100);
    phase("wr0_access", a + 2, 3'b110);
    phase("wr0_idle",   a + 3, 3'b001);
    check("wr0_paddr_hold",  32'(bus.PADDR), 32'h1);
    check("wr0_pwdata_hold", bus.PWDATA,     32'h12345678);

    // Read with 3 wait states (PREADY in the TIMEOUT-th ACCESS cycle).
    issue(1'b0, 18'h40, 32'h0, 3, 32'hCAFEF00D, 1'b1, a);
    bus.req_valid = 1'b0;
    drain();
    phase("rd3_setup",   a + 1, 3'b100);
    phase("rd3_access1", a + 2, 3'b110);
    phase("rd3_access4", a + 5, 3'b110);
    phase("rd3_idle",    a + 6, 3'b001);

    // Timeout with PREADY stuck low.
    issue(1'b1, 18'h7, 32'h55AA55AA, 1000, 32'h0, 1'b1, a);
    bus.req_valid = 1'b0;
    drain();
    phase("to_access4", a + 5, 3'b110);
    phase("to_idle",    a + 6, 3'b001);
    check("to_rdata_hold", bus.rsp_rdata, 32'hDEADBEEF);
    check("to_err_hold",   32'(bus.rsp_err), 32'd1);

    // PREADY rising in the 4th ACCESS cycle at the top address: normal completion.
    issue(1'b0, 18'h3FFFF, 32'h0, 3, 32'h89ABCDEF, 1'b1, a);
    bus.req_valid = 1'b0;
    drain();
    check("edge_rdata_hold", bus.rsp_rdata, 32'h89ABCDEF);
    check("edge_valid_low",  32'(bus.rsp_valid), 32'd0);

    // Back-to-back write then read with req_valid held high.
    issue(1'b1, 18'h2, 32'hA5A5A5A5, 0, 32'h0, 1'b1, a);
    issue(1'b0, 18'h3, 32'h0, 0, 32'h13572468, 1'b1, a2);
    bus.req_valid = 1'b0;
    drain();
    check("b2b_spacing", 32'(a2 - a), 32'd3);
    phase("b2b_busy1",  a + 1, 3'b100);
    phase("b2b_busy2",  a + 2, 3'b110);
    phase("b2b_ready",  a + 3, 3'b001);
    phase("b2b_setup2", a + 4, 3'b100);

    // Reset asserted during the 2nd wait cycle of a stalled read.
    issue(1'b0, 18'h2A, 32'h0, 1000, 32'h0, 1'b0, a);
    @(negedge PCLK);
    bus.req_valid = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("mid_rst_psel",      32'(bus.PSEL),      32'd0);
    check("mid_rst_penable",   32'(bus.PENABLE),   32'd0);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    PRESET = 1'b0;
    @(negedge PCLK);
    issue(1'b0, 18'h2B, 32'h0, 1, 32'h600DF00D, 1'b1, a);
    bus.req_valid = 1'b0;
    drain();
    phase("after_rst_idle", a + 4, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_initiator.md
# apb_initiator

APB initiator (master) that turns a single-outstanding, valid/ready request interface into APB transfers toward peripheral register wrappers on the APB bus, such as the watchdog, timer and GPIO wrappers. It runs the SETUP/ACCESS sequence, honours PREADY wait states, aborts stalled transfers with a programmable timeout, and returns read data and error status on a one-cycle response strobe.

## Interface
- TIMEOUT, 16'd255: maximum ACCESS cycles per transfer; 0 disables the timeout; range 0..65535.
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  initiator can accept a request; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  18  word address, maps to PADDR[19:2].
- req_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  32  read data; 0 for writes; 32'hDEADBEEF on timeout.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- PSEL  out  1  APB select.
- PADDR  out  18  APB address [19:2].
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready; sampled only in ACCESS.

## Operation
- States:
  - IDLE: PSEL=0, PENABLE=0, req_ready=1.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
- Accept: req_valid & req_ready at a PCLK edge.
  - Latches req_addr to PADDR, req_write to PWRITE, req_wdata to PWDATA (latched on reads too).
  - Next state SETUP.
- SETUP always lasts exactly one cycle, then goes to ACCESS.
- ACCESS with PREADY=1:
  - Transfer completes; next state IDLE.
  - rsp_rdata <= PRWRITE ? 0 : PRDATA — i.e. PRDATA on reads, 0 on writes.
  - rsp_err <= 0; rsp_valid <= 1.
- Wait counter (16-bit):
  - Cleared on entry to ACCESS.
  - Increments in each ACCESS cycle with PREADY=0.
- Timeout (TIMEOUT≠0): if PREADY=0 in the TIMEOUT-th ACCESS cycle (counter == TIMEOUT-1), abort.
  - Next state IDLE; PSEL and PENABLE drop.
  - rsp_valid <= 1, rsp_err <= 1, rsp_rdata <= 32'hDEADBEEF.
- PREADY=1 in the TIMEOUT-th ACCESS cycle is a normal completion, not a timeout.
- TIMEOUT=0: ACCESS waits indefinitely for PREADY.
- PADDR, PWRITE and PWDATA:
  - Stable from SETUP through the last ACCESS cycle.
  - Hold their last values in IDLE; change only on accept.
- rsp_valid is high for exactly one cycle. rsp_rdata and rsp_err hold until the next completion.
- Only one transfer is outstanding at a time. Requests arriving outside IDLE are not accepted; the requester must hold req_valid.
- Reset: synchronous.
  - State IDLE; PSEL, PENABLE and PWRITE are 0; PADDR and PWDATA are 0.
  - rsp_valid, rsp_err and rsp_rdata are 0; wait counter is 0.
  - req_ready is 0 while PRESET is high. Requests presented during reset are ignored.
- Reset mid-transfer (SETUP or ACCESS): the bus returns to IDLE values at that edge and no rsp_valid is produced.

## Timing
- Accept edge at cycle 0. SETUP is cycle 1; ACCESS starts at cycle 2.
- Zero-wait transfer: completes on the cycle-2 edge. rsp_valid=1 and req_ready=1 in cycle 3.
- N wait states: ACCESS spans cycles 2..2+N. rsp_valid is in cycle 3+N.
- Timeout: ACCESS spans exactly TIMEOUT cycles. rsp_valid is in cycle 2+TIMEOUT.
- Back-to-back: a new request can be accepted in the same cycle as rsp_valid. Minimum spacing is 3 cycles per transfer.
- req_ready is combinational from state and PRESET only; there is no path from req_valid to req_ready.
- All other outputs are registered.

## Test plan
- Reset: hold PRESET 2 cycles with req_valid=1 → all outputs 0 and req_ready=0 during reset; no transfer starts.
- Zero-wait write: addr 18'h1, data 32'h12345678, PREADY=1 → PSEL in cycles 1–2, PENABLE in cycle 2, PADDR=18'h1, PWDATA=32'h12345678; rsp_valid in cycle 3 with rsp_err=0 and rsp_rdata=0.
- Read with 3 wait states: addr 18'h40, PREADY low for 3 ACCESS cycles, PRDATA=32'hCAFEF00D → ACCESS lasts 4 cycles; rsp_valid in cycle 6 with rsp_rdata=32'hCAFEF00D and rsp_err=0.
- Timeout, TIMEOUT=4, PREADY stuck 0 → exactly 4 ACCESS cycles, then PSEL=0; rsp_err=1, rsp_rdata=32'hDEADBEEF. Repeat with PREADY rising in the 4th ACCESS cycle → rsp_err=0.
- Back-to-back: req_valid held high for 2 requests (write then read), PREADY=1 → req_ready low in cycles 1–2; second SETUP in cycle 4; two rsp_valid pulses, in cycles 3 and 6.
- Reset in ACCESS: PRESET asserted in the 2nd wait cycle → PSEL and PENABLE are 0 after that edge; no rsp_valid; the next request after reset completes normally.
